// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Several requesters share one UART transmit line. In IDLE a round-robin
//   arbiter picks one requester with a valid byte, the byte is captured, and
//   an 8N1 frame (start, 8 data bits LSB first, stop) is sent. Each bit lasts
//   CLKS_PER_BIT clock cycles.
//
// Ports
//   clk        : clock, all state updates on its rising edge
//   rst        : asynchronous active-high reset
//   req_valid  : [NREQ-1:0] requester i offers a byte
//   req_data   : [8*NREQ-1:0] byte of requester i on bits [8i+7:8i]
//   req_ready  : [NREQ-1:0] one-hot acceptance, combinational, only in IDLE
//   uart_tx_o  : registered serial line, idle high
//   busy       : high while a frame is on the line
//   grant_id   : [2:0] requester of the current or most recent frame
//   tx_done    : one-cycle pulse in the last stop-bit cycle
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NREQ         = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                uart_tx_o,
    output logic                busy,
    output logic [2:0]          grant_id,
    output logic                tx_done
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LAST_INIT = 3'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       grant_q, grant_d;
    logic [2:0]       last_grant_q, last_grant_d;

    logic             win_found;
    logic [2:0]       win_idx;
    logic [7:0]       win_data;
    logic             accept;

    // Round-robin search starting just after the last accepted requester.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = 3'd0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = 3'(idx);
            end else begin
                win_found = win_found;
            end
        end
    end

    // One-hot ready for the winner; gated by rst so reset forces it to zero.
    always_comb begin
        req_ready = '0;
        win_data  = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == 3'(i)) begin
                req_ready[i] = !rst && (state_q == IDLE) && win_found;
                win_data     = req_data[8*i +: 8];
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    assign accept = |req_ready;

    // Frame sequencer: next state, baud/bit counters, shifter and line level.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        tx_d         = tx_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                bit_d = 3'd0;
                if (accept) begin
                    state_d      = START;
                    shreg_d      = win_data;
                    grant_d      = win_idx;
                    last_grant_d = win_idx;
                    tx_d         = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = 3'd0;
                        tx_d    = 1'b1;
                    end else begin
                        // Shifter keeps the bit on the line at position 0.
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = 3'd0;
                tx_d    = 1'b1;
            end
        endcase
        // Status outputs are registered, so derive them from the next state.
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
    end

    // State register; reset forces the line high immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shreg_q      <= 8'h00;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            grant_q      <= 3'd0;
            last_grant_q <= LAST_INIT;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign uart_tx_o = tx_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with CLKS_PER_BIT=4, NREQ=3.
module tb_uart_tx_arbiter;

    localparam int CPB = 4;
    localparam int NR  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_ready;
    logic        uart_tx_o;
    logic        busy;
    logic [2:0]  grant_id;
    logic        tx_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int last_acc = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure acceptance spacing.
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .NREQ(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .uart_tx_o (uart_tx_o),
        .busy      (busy),
        .grant_id  (grant_id),
        .tx_done   (tx_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level for each of the 40 frame cycles (index 0 = cycle 1).
    function automatic logic [39:0] frame_of(input logic [7:0] b);
        logic [39:0] f;
        int j;
        for (int k = 0; k < 40; k++) begin
            j = k / 4;
            if (j == 0)      f[k] = 1'b0;
            else if (j == 9) f[k] = 1'b1;
            else             f[k] = b[j-1];
        end
        return f;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Called in an IDLE cycle with inputs set. Checks ready, accepts, records
    // the 40-cycle frame, then steps into the following IDLE cycle.
    // v1/d1 are applied in frame cycle 1, v2 in frame cycle 20.
    task automatic do_frame(input string tag, input logic [2:0] exp_rdy,
                            input logic [2:0] exp_gid, input logic [7:0] exp_byte,
                            input logic [2:0] v1, input logic [23:0] d1,
                            input logic [2:0] v2, input int exp_gap);
        logic [39:0] line, done, bsy;
        logic [2:0]  rdy_or;
        logic [7:0]  dec;
        int acc;
        #1;
        check({tag, "_ready"}, req_ready, exp_rdy);
        @(posedge clk); #1;
        acc = cyc;
        if (exp_gap != 0) check({tag, "_gap"}, acc - last_acc, exp_gap);
        last_acc = acc;
        check({tag, "_gid"}, grant_id, exp_gid);
        rdy_or = 3'b000;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            line[k-1] = uart_tx_o;
            done[k-1] = tx_done;
            bsy[k-1]  = busy;
            if (k == 1) begin
                req_valid = v1;
                req_data  = d1;
            end
            if (k == 20) req_valid = v2;
            #1;
            rdy_or = rdy_or | req_ready;
        end
        for (int i = 0; i < 8; i++) dec[i] = line[4*(i+1)+1];
        check({tag, "_line"}, line, frame_of(exp_byte));
        check({tag, "_byte"}, dec, exp_byte);
        check({tag, "_done"}, done, 40'h80_0000_0000);
        check({tag, "_busy"}, bsy, 40'hFF_FFFF_FFFF);
        check({tag, "_holdoff"}, rdy_or, 3'b000);
        @(posedge clk); #1;
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_idle_tx"}, uart_tx_o, 1'b1);
        check({tag, "_idle_done"}, tx_done, 1'b0);
    endtask

    initial begin
        logic       line_and;
        logic       busy_or;

        // Reset values, with all requesters valid to show ready is gated.
        rst       = 1'b1;
        req_valid = 3'b111;
        req_data  = 24'h000000;
        #12;
        check("rst_tx", uart_tx_o, 1'b1);
        check("rst_ready", req_ready, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_gid", grant_id, 3'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 3'b000;

        // Single byte 0x55 from requester 0.
        req_data  = 24'h000055;
        req_valid = 3'b001;
        do_frame("single", 3'b001, 3'd0, 8'h55, 3'b000, 24'h000055, 3'b000, 0);

        // Round-robin with all three held valid.
        do_reset();
        req_data  = 24'h434241;
        req_valid = 3'b111;
        do_frame("rr0", 3'b001, 3'd0, 8'h41, 3'b111, 24'h434241, 3'b111, 0);
        do_frame("rr1", 3'b010, 3'd1, 8'h42, 3'b111, 24'h434241, 3'b111, 41);
        do_frame("rr2", 3'b100, 3'd2, 8'h43, 3'b111, 24'h434241, 3'b111, 41);
        do_frame("rr3", 3'b001, 3'd0, 8'h41, 3'b000, 24'h434241, 3'b000, 41);

        // Hold-off while busy, and data changed after capture.
        do_reset();
        req_data  = 24'h00963C;
        req_valid = 3'b001;
        do_frame("hold_a", 3'b001, 3'd0, 8'h3C, 3'b010, 24'h00963C, 3'b010, 0);
        do_frame("hold_b", 3'b010, 3'd1, 8'h96, 3'b000, 24'h00003C, 3'b000, 41);

        // Reset in the middle of the data bits.
        req_data  = 24'h000000;
        req_valid = 3'b001;
        #1;
        check("mid_ready", req_ready, 3'b001);
        @(posedge clk); #1;
        req_valid = 3'b000;
        for (int k = 2; k <= 15; k++) begin
            @(posedge clk); #1;
        end
        check("mid_tx_low", uart_tx_o, 1'b0);
        check("mid_busy", busy, 1'b1);
        req_valid = 3'b001;
        rst       = 1'b1;
        #1;
        check("abort_tx", uart_tx_o, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", req_ready, 3'b000);
        check("abort_gid", grant_id, 3'd0);
        req_valid = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        line_and = 1'b1;
        busy_or  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            line_and = line_and & uart_tx_o;
            busy_or  = busy_or | busy;
        end
        check("noretx_line", line_and, 1'b1);
        check("noretx_busy", busy_or, 1'b0);

        // Priority after reset, then withdrawal of requester 0.
        req_data  = 24'hC39600;
        req_valid = 3'b101;
        #1;
        check("prio_101", req_ready, 3'b001);
        req_valid = 3'b100;
        do_frame("wd_a", 3'b100, 3'd2, 8'hC3, 3'b101, 24'hC39600, 3'b100, 0);
        do_frame("wd_b", 3'b100, 3'd2, 8'hC3, 3'b000, 24'hC39600, 3'b000, 41);
        line_and = 1'b1;
        busy_or  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            line_and = line_and & uart_tx_o;
            busy_or  = busy_or | busy;
        end
        check("final_idle_line", line_and, 1'b1);
        check("final_idle_busy", busy_or, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
